// File: rtl/csa_seq_mult_pkg.sv
// Shared definitions for the carry-save sequential multiplier:
// FSM state encoding and the product-width helper.
package csa_seq_mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int PROD_SCALE = 2;

   function automatic int prod_width(input int bits);
      return PROD_SCALE * bits;
   endfunction

endpackage

// File: rtl/csa_row.sv
// Combinational 3:2 compressor row: s = x^y^z, c = maj(x,y,z) << 1, truncated to WIDTH.
module csa_row #(
   parameter int WIDTH = 64
) (
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic [WIDTH-1:0] z,
   output logic [WIDTH-1:0] s,
   output logic [WIDTH-1:0] c
);

   assign c[0] = 1'b0;

   // The top bit's majority would shift past WIDTH, so only its sum is built.
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (i < WIDTH - 1) begin : g_fa
         fulladder u_fa (
            .a_i  (x[i]),
            .b_i  (y[i]),
            .ci_i (z[i]),
            .s_o  (s[i]),
            .co_o (c[i+1])
         );
      end else begin : g_top
         assign s[i] = x[i] ^ y[i] ^ z[i];
      end
   end

endmodule

// File: rtl/fulladder.sv
// Single-bit full adder; the building block of the carry-save compressor row.
module fulladder (
   input  logic a_i,
   input  logic b_i,
   input  logic ci_i,
   output logic s_o,
   output logic co_o
);

   assign s_o  = a_i ^ b_i ^ ci_i;
   assign co_o = (a_i & b_i) | (a_i & ci_i) | (b_i & ci_i);

endmodule

// File: rtl/csa_seq_mult.sv
// Sequential BITS x BITS unsigned multiplier, one multiplier bit per cycle, result left in carry-save form.
// Optional build macro CSA_SEQ_MULT_EARLY_TERM_EN: leave RUN as soon as the remaining multiplier bits are zero.
module csa_seq_mult
   import csa_seq_mult_pkg::*;
#(
   parameter int BITS = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [BITS-1:0]   in_a,
   input  logic [BITS-1:0]   in_b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [2*BITS-1:0] out_s,
   output logic [2*BITS-1:0] out_c
);

   localparam int PW    = prod_width(BITS);
   localparam int CNT_W = $clog2(BITS);

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [PW-1:0]    mcand_q;
   logic [BITS-1:0]  mplr_q;
   logic [PW-1:0]    acc_s_q;
   logic [PW-1:0]    acc_c_q;
   logic             in_ready_q;
   logic             out_valid_q;

   logic [PW-1:0]    pp_d;
   logic [PW-1:0]    row_s_d;
   logic [PW-1:0]    row_c_d;
   logic             last_run_d;

   // Partial product selected by the current low multiplier bit.
   always_comb begin
      if (mplr_q[0]) begin
         pp_d = mcand_q;
      end else begin
         pp_d = {PW{1'b0}};
      end
   end

   // Decide whether the current RUN cycle is the final one.
   always_comb begin
      last_run_d = 1'b0;
`ifdef CSA_SEQ_MULT_EARLY_TERM_EN
      if ((cnt_q == CNT_W'(BITS - 1)) || (mplr_q[BITS-1:1] == {(BITS-1){1'b0}})) begin
         last_run_d = 1'b1;
      end else begin
         last_run_d = 1'b0;
      end
`else
      if (cnt_q == CNT_W'(BITS - 1)) begin
         last_run_d = 1'b1;
      end else begin
         last_run_d = 1'b0;
      end
`endif
   end

   csa_row #(
      .WIDTH (PW)
   ) u_row (
      .x (acc_s_q),
      .y (acc_c_q),
      .z (pp_d),
      .s (row_s_d),
      .c (row_c_d)
   );

   // Control FSM and datapath registers; handshake flags are registered alongside the state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= {CNT_W{1'b0}};
         mcand_q     <= {PW{1'b0}};
         mplr_q      <= {BITS{1'b0}};
         acc_s_q     <= {PW{1'b0}};
         acc_c_q     <= {PW{1'b0}};
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  mcand_q    <= {{BITS{1'b0}}, in_a};
                  mplr_q     <= in_b;
                  acc_s_q    <= {PW{1'b0}};
                  acc_c_q    <= {PW{1'b0}};
                  cnt_q      <= {CNT_W{1'b0}};
                  in_ready_q <= 1'b0;
                  state_q    <= RUN;
               end
            end
            RUN: begin
               acc_s_q <= row_s_d;
               acc_c_q <= row_c_d;
               mcand_q <= mcand_q << 1;
               mplr_q  <= mplr_q >> 1;
               cnt_q   <= cnt_q + CNT_W'(1);
               if (last_run_d) begin
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_s     = acc_s_q;
   assign out_c     = acc_c_q;

endmodule

// File: tb/tb_csa_seq_mult.sv
// Scoreboard bench for csa_seq_mult (BITS=8): driver pushes expected products, a monitor checks results.
// Latency is counted in rising edges including the accepting edge.
`timescale 1ns/1ps
module tb_csa_seq_mult;

   localparam int BITS = 8;
`ifdef CSA_SEQ_MULT_EARLY_TERM_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   logic        clk       = 1'b0;
   logic        rst_n     = 1'b0;
   logic        in_valid  = 1'b0;
   logic        out_ready = 1'b1;
   logic [7:0]  in_a      = 8'h00;
   logic [7:0]  in_b      = 8'h00;
   logic        in_ready;
   logic        out_valid;
   logic [15:0] out_s;
   logic [15:0] out_c;

   typedef struct packed {
      logic [15:0] prod;
      int          lat;
   } exp_t;

   exp_t exp_q[$];
   int   acc_edge_q[$];
   int   checks   = 0;
   int   errors   = 0;
   int   edge_cnt = 0;
   int   accepted = 0;
   int   results  = 0;
   bit   rnd_mode = 1'b0;

   csa_seq_mult #(
      .BITS (BITS)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_s     (out_s),
      .out_c     (out_c)
   );

   always #5 clk = ~clk;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   function automatic int exp_lat(input logic [7:0] b);
      int runs;
      runs = 1;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) runs = i + 1;
      end
      return (EARLY ? runs : BITS) + 1;
   endfunction

   // Drive one operand pair, hold in_valid until accepted, then record the expectation.
   task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [15:0] prod);
      int n;
      exp_t e;
      n = 0;
      in_a = a;
      in_b = b;
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: in_ready low for %0d cycles, expected 1", n);
      end else begin
         e.prod = prod;
         e.lat  = exp_lat(b);
         exp_q.push_back(e);
         accepted++;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_drain(input string name, input int limit);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || !in_ready) && n < limit) begin
         @(posedge clk);
         #1;
         n++;
      end
      checks++;
      if (n >= limit) begin
         errors++;
         $display("FAIL %s: %0d jobs still pending after %0d cycles, expected 0", name, exp_q.size(), n);
      end
   endtask

   // Monitor: latency on out_valid rise, stability while stalled, product on handshake.
   initial begin : monitor
      logic        ov_prev;
      logic [15:0] hs;
      logic [15:0] hc;
      exp_t        e;
      int          ae;
      ov_prev = 1'b0;
      hs = 16'h0000;
      hc = 16'h0000;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            ov_prev = 1'b0;
         end else begin
            if (in_valid && in_ready) acc_edge_q.push_back(edge_cnt + 1);
            if (out_valid) begin
               if (!ov_prev) begin
                  if (exp_q.size() == 0 || acc_edge_q.size() == 0) begin
                     checks++;
                     errors++;
                     $display("FAIL unexpected_result: out_valid=1 with no job pending, expected 0");
                  end else begin
                     ae = acc_edge_q.pop_front();
                     chk("latency", edge_cnt - ae + 1, exp_q[0].lat);
                  end
                  hs = out_s;
                  hc = out_c;
               end else begin
                  chk("hold_s", out_s, hs);
                  chk("hold_c", out_c, hc);
               end
               if (out_ready && exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  chk("product", 16'(out_s + out_c), e.prod);
                  results++;
               end
            end
            ov_prev = out_valid;
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      errors++;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int n;
      logic [7:0] ra;
      logic [7:0] rb;
      #12;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_s", out_s, 0);
      chk("rst_out_c", out_c, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Fixed-latency job and hand-computed products
      send(8'h0F, 8'h0F, 16'h00E1);
      wait_drain("drain_0f", 50);
      send(8'h37, 8'h03, 16'h00A5);
      wait_drain("drain_37", 50);
      send(8'h00, 8'hA5, 16'h0000);
      wait_drain("drain_zero_a", 50);
      send(8'h5A, 8'h00, 16'h0000);
      wait_drain("drain_zero_b", 50);
      send(8'h80, 8'h80, 16'h4000);
      wait_drain("drain_80", 50);

      // Full scale with 5 cycles of backpressure
      out_ready = 1'b0;
      send(8'hFF, 8'hFF, 16'hFE01);
      n = 0;
      while (!out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("bp_out_valid", out_valid, 1);
      repeat (5) @(negedge clk);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_idle_in_ready", in_ready, 1);
      chk("bp_idle_out_valid", out_valid, 0);
      wait_drain("drain_ff", 20);

      // Reset in the middle of RUN abandons the job
      send(8'h12, 8'h34, 16'h03A8);
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      exp_q.delete();
      acc_edge_q.delete();
      accepted = results;
      #1;
      chk("midrst_in_ready", in_ready, 1);
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_out_s", out_s, 0);
      chk("midrst_out_c", out_c, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      chk("post_rst_out_valid", out_valid, 0);
      chk("post_rst_in_ready", in_ready, 1);

      // Random stream with input gaps and output stalls
      rnd_mode = 1'b1;
      fork
         begin : ready_toggler
            while (rnd_mode) begin
               @(posedge clk);
               #1;
               out_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join_none
      for (int i = 0; i < 1000; i++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         if (i % 4 == 0) rb = rb >> $urandom_range(0, 7);
         send(ra, rb, 16'(ra) * 16'(rb));
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
      end
      rnd_mode = 1'b0;
      @(posedge clk);
      #2;
      out_ready = 1'b1;
      wait_drain("drain_random", 300);
      chk("jobs_accounted", results, accepted);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
